// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register data width and register map.
package gpio_bank_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_OUT        = 3'd0;
    localparam logic [2:0] ADDR_OE         = 3'd1;
    localparam logic [2:0] ADDR_IN         = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN    = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK   = 3'd6;
    localparam logic [2:0] ADDR_RSVD       = 3'd7;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: synchroniser, stable-count debouncer and edge pulses.
module gpio_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_async,
    output logic deb_out,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   deb_dly_q;

    // Synchroniser chain for the asynchronous pad input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_async};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: the output only follows s after DEB_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign deb_out = deb_q;
    assign rise    = deb_q & ~deb_dly_q;
    assign fall    = ~deb_q & deb_dly_q;

endmodule

// File: rtl/gpio_bank.sv
// N-channel GPIO core: pad drive registers, debounced inputs, sticky edge
// interrupts and a single-cycle register port with registered read data.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   pad_p2c,
    output logic [N_CH-1:0]   pad_c2p,
    output logic [N_CH-1:0]   pad_c2p_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              irq
);

    logic [N_CH-1:0]   out_q, out_d;
    logic [N_CH-1:0]   oe_q, oe_d;
    logic [N_CH-1:0]   rise_en_q, rise_en_d;
    logic [N_CH-1:0]   fall_en_q, fall_en_d;
    logic [N_CH-1:0]   status_q, status_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;

    logic [N_CH-1:0]   deb_vec;
    logic [N_CH-1:0]   rise_vec;
    logic [N_CH-1:0]   fall_vec;
    logic [N_CH-1:0]   irq_set;
    logic [N_CH-1:0]   irq_clr;
    logic [N_CH-1:0]   wdata_n;
    logic [DATA_W-1:0] rd_word;
    logic              unused_wr_data;

    assign wdata_n        = wr_data[N_CH-1:0];
    assign unused_wr_data = ^wr_data;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .in_async (pad_p2c[i]),
            .deb_out  (deb_vec[i]),
            .rise     (rise_vec[i]),
            .fall     (fall_vec[i])
        );
    end

    assign irq_set = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);

    // Register writes, sticky status (set beats clear) and irq next-state.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        mask_d    = mask_q;
        irq_clr   = '0;
        if (wr_en) begin
            case (addr)
                ADDR_OUT:        out_d     = wdata_n;
                ADDR_OE:         oe_d      = wdata_n;
                ADDR_RISE_EN:    rise_en_d = wdata_n;
                ADDR_FALL_EN:    fall_en_d = wdata_n;
                ADDR_IRQ_STATUS: irq_clr   = wdata_n;
                ADDR_IRQ_MASK:   mask_d    = wdata_n;
                default:         ;
            endcase
        end
        status_d = (status_q & ~irq_clr) | irq_set;
        irq_d    = |(status_d & mask_q);
    end

    // Read mux: samples pre-write register values, holds data between reads.
    always_comb begin
        rd_word   = '0;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            case (addr)
                ADDR_OUT:        rd_word[N_CH-1:0] = out_q;
                ADDR_OE:         rd_word[N_CH-1:0] = oe_q;
                ADDR_IN:         rd_word[N_CH-1:0] = deb_vec;
                ADDR_RISE_EN:    rd_word[N_CH-1:0] = rise_en_q;
                ADDR_FALL_EN:    rd_word[N_CH-1:0] = fall_en_q;
                ADDR_IRQ_STATUS: rd_word[N_CH-1:0] = status_q;
                ADDR_IRQ_MASK:   rd_word[N_CH-1:0] = mask_q;
                default:         rd_word           = '0;
            endcase
            rd_data_d = rd_word;
        end
    end

    // All register-port and interrupt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            oe_q       <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            oe_q       <= oe_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en;
        end
    end

    assign pad_c2p    = out_q;
    assign pad_c2p_en = oe_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: behavioural model plus directed scenarios.
module tb_gpio_bank;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic        clk;
    logic        rst;
    logic [N-1:0] pad_p2c;
    logic [N-1:0] pad_c2p;
    logic [N-1:0] pad_c2p_en;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    gpio_bank #(
        .N_CH        (N),
        .SYNC_STAGES (SYNC),
        .DEB_CYCLES  (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pad_p2c    (pad_p2c),
        .pad_c2p    (pad_c2p),
        .pad_c2p_en (pad_c2p_en),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register array indexed by address, pad history
    // delayed by the synchroniser depth, and a debounced value that flips once
    // the last DEB synchronised samples all disagree with it.
    logic [N-1:0] m_reg [8];
    logic [N-1:0] m_sync [SYNC];
    logic [N-1:0] m_hist [DEB];
    logic [N-1:0] m_d, m_dq;
    logic [31:0]  m_rd_data;
    logic         m_rd_valid, m_irq;
    bit           model_valid = 0;

    always @(posedge clk) begin
        logic [N-1:0] s_now, set_v, old_mask;
        bit all_diff;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
            for (int i = 0; i < DEB; i++) m_hist[i] = '0;
            m_d = '0; m_dq = '0; m_rd_data = '0; m_rd_valid = 1'b0; m_irq = 1'b0;
            model_valid = 1;
        end else begin
            s_now    = m_sync[SYNC-1];
            set_v    = ((m_d & ~m_dq) & m_reg[3]) | ((~m_d & m_dq) & m_reg[4]);
            old_mask = m_reg[6];
            m_rd_valid = rd_en;
            if (rd_en) begin
                if (addr == 3'd2)      m_rd_data = 32'(m_d);
                else if (addr == 3'd7) m_rd_data = 32'd0;
                else                   m_rd_data = 32'(m_reg[addr]);
            end
            if (wr_en) begin
                if (addr == 3'd5)                      m_reg[5] = m_reg[5] & ~wr_data[N-1:0];
                else if (addr != 3'd2 && addr != 3'd7) m_reg[addr] = wr_data[N-1:0];
            end
            m_reg[5] = m_reg[5] | set_v;
            m_irq    = |(m_reg[5] & old_mask);
            for (int i = DEB-1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = s_now;
            m_dq = m_d;
            for (int c = 0; c < N; c++) begin
                all_diff = 1;
                for (int j = 0; j < DEB; j++)
                    if (m_hist[j][c] == m_d[c]) all_diff = 0;
                if (all_diff) m_d[c] = ~m_d[c];
            end
            for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = pad_p2c;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("m_pad_c2p", 32'(pad_c2p), 32'(m_reg[0]));
            chk("m_pad_c2p_en", 32'(pad_c2p_en), 32'(m_reg[1]));
            chk("m_irq", 32'(irq), 32'(m_irq));
            chk("m_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("m_rd_data", rd_data, m_rd_data);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0; wr_data = 32'd0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        rd_en = 1'b1; addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk(name, rd_data, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; pad_p2c = '0; wr_en = 1'b0; rd_en = 1'b0; addr = 3'd0; wr_data = 32'd0;
        idle(3);
        rst = 1'b0;

        // Reset state
        for (int a = 0; a < 8; a++) rd_chk("reset_rd", 3'(a), 32'd0);
        idle(1);
        chk("reset_rd_valid_low", 32'(rd_valid), 32'd0);
        chk("reset_oe", 32'(pad_c2p_en), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);

        // Output path
        wr(3'd1, 32'h0000_00A5);
        chk("oe_a5", 32'(pad_c2p_en), 32'h0000_00A5);
        wr(3'd0, 32'h0000_00FF);
        chk("out_ff", 32'(pad_c2p), 32'h0000_00FF);
        wr(3'd0, 32'hFFFF_FF00);
        chk("out_upper_ignored", 32'(pad_c2p), 32'd0);
        rd_chk("out_readback", 3'd0, 32'd0);

        // Debounced rising edge: irq exactly 7 edges after first sampling edge
        wr(3'd3, 32'h1);
        wr(3'd6, 32'h1);
        pad_p2c[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("rise_irq_at6", 32'(irq), 32'd0);
        @(posedge clk);
        #1 chk("rise_irq_at7", 32'(irq), 32'd1);
        @(negedge clk);
        rd_chk("rise_in", 3'd2, 32'h01);
        rd_chk("rise_status", 3'd5, 32'h01);

        // Glitch rejection: 3-cycle pulse on channel 3
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'hFF);
        wr(3'd5, 32'h01);
        chk("clear_irq", 32'(irq), 32'd0);
        pad_p2c[3] = 1'b1;
        idle(3);
        pad_p2c[3] = 1'b0;
        idle(12);
        rd_chk("glitch_in", 3'd2, 32'h01);
        rd_chk("glitch_status", 3'd5, 32'h00);

        // W1C racing against a new fall on channel 0
        pad_p2c[0] = 1'b0;
        idle(12);
        rd_chk("fall_status", 3'd5, 32'h01);
        pad_p2c[0] = 1'b1;
        idle(12);
        rd_chk("rise2_status", 3'd5, 32'h01);
        pad_p2c[0] = 1'b0;
        idle(6);
        wr(3'd5, 32'h01);
        rd_chk("w1c_race_status", 3'd5, 32'h01);
        chk("w1c_race_irq", 32'(irq), 32'd1);
        wr(3'd5, 32'h01);
        chk("w1c_irq_drop", 32'(irq), 32'd0);
        rd_chk("w1c_status", 3'd5, 32'h00);

        // Reset in the middle of a debounce on channel 5
        pad_p2c[5] = 1'b1;
        idle(4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(5);
        rd_chk("rst_in_before", 3'd2, 32'h00);
        rd_chk("rst_in_after6", 3'd2, 32'h20);
        rd_chk("rst_status", 3'd5, 32'h00);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_oe", 32'(pad_c2p_en), 32'd0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
